// File: rtl/audio_fifo_pkg.sv
// Register map and bit positions shared by the audio FIFO slot.
package audio_fifo_pkg;

  typedef enum logic [2:0] {
    REG_DATA     = 3'd0,
    REG_CTRL     = 3'd1,
    REG_STATUS   = 3'd2,
    REG_THRESH   = 3'd3,
    REG_UNDERRUN = 3'd4
  } reg_addr_e;

  // CTRL bits
  localparam int unsigned CTRL_ENABLE   = 0;
  localparam int unsigned CTRL_FIFO_CLR = 1;
  localparam int unsigned CTRL_FLAG_CLR = 2;
  localparam int unsigned CTRL_IRQ_EN   = 3;

  // STATUS bits
  localparam int unsigned ST_EMPTY    = 0;
  localparam int unsigned ST_FULL     = 1;
  localparam int unsigned ST_OVERFLOW = 2;
  localparam int unsigned ST_IRQ_RAW  = 3;
  localparam int unsigned ST_LEVEL    = 16;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

endpackage

// File: rtl/audio_fifo_core_fifo_sync.sv
// Single-clock FIFO with registered read data (BRAM style).
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   wr_en_i, wr_data_i      push (ignored when full or clearing)
//   rd_en_i                 pop head into rd_data_o (ignored when empty or clearing)
//   rd_zero_i               load zero into rd_data_o when not popping
//   clr_i                   reset pointers and level
//   rd_data_o               registered read data
//   full_o, empty_o, level_o status
module fifo_sync #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  input  logic                  rd_zero_i,
  input  logic                  clr_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [WIDTH-1:0]      rd_data_q;
  logic                  wr_ok, rd_ok;

  assign full_o  = (level_q == FULL_LEVEL);
  assign empty_o = (level_q == '0);
  assign wr_ok   = wr_en_i & ~full_o & ~clr_i;
  assign rd_ok   = rd_en_i & ~empty_o & ~clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (rd_ok)          rd_data_q <= mem_q[rd_ptr_q];
      else if (rd_zero_i) rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;
  assign level_o   = level_q;

endmodule

// File: rtl/audio_fifo_core.sv
// MMIO slot buffering stereo PCM samples for the I2S transmitter.
// Ports:
//   i_clk, i_reset                     clock, synchronous active-high reset
//   i_cs, i_write, i_read, i_addr      MMIO slot access (only i_addr[2:0] decoded)
//   i_write_data, o_read_data          MMIO data (read data combinational)
//   i_sample_req                       consumer request pulse
//   o_sample_left/right, o_sample_strobe  sample answered one cycle after request
//   o_irq                              registered low-water interrupt
module audio_fifo_core
  import audio_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned SAMPLE_W   = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cs,
  input  logic                i_write,
  input  logic                i_read,
  input  logic [4:0]          i_addr,
  input  logic [31:0]         i_write_data,
  output logic [31:0]         o_read_data,
  input  logic                i_sample_req,
  output logic [SAMPLE_W-1:0] o_sample_left,
  output logic [SAMPLE_W-1:0] o_sample_right,
  output logic                o_sample_strobe,
  output logic                o_irq
);

  logic                enable_q, enable_d;
  logic                irq_en_q, irq_en_d;
  logic [DEPTH_LOG2:0] thresh_q, thresh_d;
  logic                ovf_q, ovf_d;
  logic [15:0]         underrun_q, underrun_d;
  logic                strobe_q, irq_q, irq_d;

  logic [2*SAMPLE_W-1:0] rd_data;
  logic                  full, empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  irq_raw;

  reg_addr_e reg_addr;
  logic      wr_data, wr_ctrl, wr_thresh;
  logic      fifo_clr, flag_clr;
  logic      push, pop, underrun;
  logic      unused;

  assign reg_addr  = reg_addr_e'(i_addr[2:0]);
  assign wr_data   = i_cs & i_write & (reg_addr == REG_DATA);
  assign wr_ctrl   = i_cs & i_write & (reg_addr == REG_CTRL);
  assign wr_thresh = i_cs & i_write & (reg_addr == REG_THRESH);
  assign fifo_clr  = wr_ctrl & i_write_data[CTRL_FIFO_CLR];
  assign flag_clr  = wr_ctrl & i_write_data[CTRL_FLAG_CLR];

  // Full is judged on the pre-pop level, so a push while full is always dropped.
  assign push     = wr_data & ~full & ~fifo_clr;
  assign pop      = i_sample_req & enable_q & ~empty & ~fifo_clr;
  assign underrun = i_sample_req & enable_q & empty & ~fifo_clr;
  assign irq_raw  = (level <= thresh_q);

  fifo_sync #(
    .WIDTH      (2*SAMPLE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i     (i_clk),
    .rst_i     (i_reset),
    .wr_en_i   (push),
    .wr_data_i ({i_write_data[16 +: SAMPLE_W], i_write_data[0 +: SAMPLE_W]}),
    .rd_en_i   (pop),
    .rd_zero_i (i_sample_req),
    .clr_i     (fifo_clr),
    .rd_data_o (rd_data),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (level)
  );

  always_comb begin
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    thresh_d   = thresh_q;
    ovf_d      = ovf_q;
    underrun_d = underrun_q;
    if (wr_ctrl) begin
      enable_d = i_write_data[CTRL_ENABLE];
      irq_en_d = i_write_data[CTRL_IRQ_EN];
    end
    if (wr_thresh) thresh_d = i_write_data[DEPTH_LOG2:0];
    if (flag_clr) begin
      ovf_d      = 1'b0;
      underrun_d = '0;
    end else begin
      if (wr_data & full & ~fifo_clr) ovf_d = 1'b1;
      if (underrun && underrun_q != UNDERRUN_MAX) underrun_d = underrun_q + 1'b1;
    end
    irq_d = irq_en_q & enable_q & irq_raw;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      thresh_q   <= '0;
      ovf_q      <= 1'b0;
      underrun_q <= '0;
      strobe_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      thresh_q   <= thresh_d;
      ovf_q      <= ovf_d;
      underrun_q <= underrun_d;
      strobe_q   <= i_sample_req;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    o_read_data = '0;
    case (reg_addr)
      REG_CTRL: begin
        o_read_data[CTRL_ENABLE] = enable_q;
        o_read_data[CTRL_IRQ_EN] = irq_en_q;
      end
      REG_STATUS: begin
        o_read_data[ST_EMPTY]    = empty;
        o_read_data[ST_FULL]     = full;
        o_read_data[ST_OVERFLOW] = ovf_q;
        o_read_data[ST_IRQ_RAW]  = irq_raw;
        o_read_data[ST_LEVEL +: DEPTH_LOG2+1] = level;
      end
      REG_THRESH:   o_read_data[DEPTH_LOG2:0] = thresh_q;
      REG_UNDERRUN: o_read_data[15:0] = underrun_q;
      default:      o_read_data = '0;
    endcase
  end

  assign o_sample_left   = rd_data[2*SAMPLE_W-1:SAMPLE_W];
  assign o_sample_right  = rd_data[SAMPLE_W-1:0];
  assign o_sample_strobe = strobe_q;
  assign o_irq           = irq_q;

  assign unused = ^{i_read, i_addr[4:3]};

endmodule

// File: tb/tb_audio_fifo_core.sv
module tb_audio_fifo_core;

  logic        clk = 1'b0;
  logic        rst, cs, wr, rd, req;
  logic [4:0]  addr;
  logic [31:0] wdata, rdata;
  logic [15:0] sl, sr;
  logic        strobe, irq;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  audio_fifo_core #(.DEPTH_LOG2(9), .SAMPLE_W(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_cs(cs), .i_write(wr), .i_read(rd),
    .i_addr(addr), .i_write_data(wdata), .o_read_data(rdata),
    .i_sample_req(req), .o_sample_left(sl), .o_sample_right(sr),
    .o_sample_strobe(strobe), .o_irq(irq)
  );

  function automatic logic [31:0] w2(input int i);
    logic [15:0] a;
    a = 16'(i);
    return {a + 16'h1000, ~a};
  endfunction

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); cs = 1; wr = 1; addr = a; wdata = d;
    @(negedge clk); cs = 0; wr = 0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    addr = a; rd = 1; #1; d = rdata; rd = 0;
  endtask

  task automatic pulse_req;
    @(negedge clk); req = 1;
    @(negedge clk); req = 0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1; cs = 0; wr = 0; rd = 0; req = 0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    nvec++;
    if ({sl, sr, strobe, irq} !== 34'h0) begin
      nerr++; $display("FAIL reset_outputs got %h want 0", {sl, sr, strobe, irq});
    end
    bus_read(5'd2, d); nvec++;
    if (d !== 32'h9) begin nerr++; $display("FAIL reset_status got %h want 00000009", d); end
    bus_read(5'd4, d); nvec++;
    if (d !== 32'h0) begin nerr++; $display("FAIL reset_underrun got %h want 0", d); end
  endtask

  task automatic test_basic;
    logic [31:0] d;
    bus_write(5'd1, 32'h1);
    bus_read(5'd1, d); nvec++;
    if (d !== 32'h1) begin nerr++; $display("FAIL ctrl_read got %h want 00000001", d); end
    bus_write(5'd0, 32'h1111_2222);
    pulse_req; nvec++;
    if ({strobe, sl, sr} !== {1'b1, 32'h1111_2222}) begin
      nerr++; $display("FAIL basic_pop got %h want 111112222", {strobe, sl, sr});
    end
    bus_read(5'd2, d); nvec++;
    if (d !== 32'h9) begin nerr++; $display("FAIL basic_status got %h want 00000009", d); end
    @(negedge clk); nvec++;
    if (strobe !== 1'b0) begin nerr++; $display("FAIL strobe_pulse got %b want 0", strobe); end
  endtask

  task automatic test_full;
    logic [31:0] d;
    for (int i = 0; i < 513; i++) begin
      @(negedge clk); cs = 1; wr = 1; addr = 5'd0;
      wdata = (i == 512) ? 32'hDEAD_BEEF : w2(i);
    end
    @(negedge clk); cs = 0; wr = 0;
    bus_read(5'd2, d); nvec++;
    if (d !== 32'h0200_0006) begin nerr++; $display("FAIL full_status got %h want 02000006", d); end
    for (int i = 0; i < 512; i++) begin
      pulse_req; nvec++;
      if ({sl, sr} !== w2(i)) begin
        nerr++; $display("FAIL drain[%0d] got %h want %h", i, {sl, sr}, w2(i));
      end
    end
    bus_read(5'd2, d); nvec++;
    if (d !== 32'hD) begin nerr++; $display("FAIL drained_status got %h want 0000000d", d); end
    bus_write(5'd1, 32'h5);
    bus_read(5'd2, d); nvec++;
    if (d !== 32'h9) begin nerr++; $display("FAIL ovf_clear got %h want 00000009", d); end
  endtask

  task automatic test_underrun;
    logic [31:0] d;
    bus_write(5'd1, 32'h0);
    pulse_req; nvec++;
    if ({strobe, sl, sr} !== 33'h1_0000_0000) begin
      nerr++; $display("FAIL disabled_req got %h want 100000000", {strobe, sl, sr});
    end
    bus_read(5'd4, d); nvec++;
    if (d !== 32'h0) begin nerr++; $display("FAIL disabled_count got %h want 0", d); end
    bus_write(5'd1, 32'h1);
    for (int i = 0; i < 3; i++) begin
      pulse_req; nvec++;
      if ({strobe, sl, sr} !== 33'h1_0000_0000) begin
        nerr++; $display("FAIL underrun_out[%0d] got %h want 100000000", i, {strobe, sl, sr});
      end
    end
    bus_read(5'd4, d); nvec++;
    if (d !== 32'h3) begin nerr++; $display("FAIL underrun_count got %h want 3", d); end
    bus_write(5'd1, 32'h5);
    bus_read(5'd4, d); nvec++;
    if (d !== 32'h0) begin nerr++; $display("FAIL underrun_clear got %h want 0", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    for (int k = 0; k < 5; k++) bus_write(5'd0, 32'hA000_0000 + 32'(k));
    bus_read(5'd2, d); nvec++;
    if (d[25:16] !== 10'd5) begin nerr++; $display("FAIL b2b_level_pre got %0d want 5", d[25:16]); end
    @(negedge clk); cs = 1; wr = 1; addr = 5'd0; wdata = 32'hA000_0005; req = 1;
    @(negedge clk); cs = 0; wr = 0; req = 0;
    nvec++;
    if ({sl, sr} !== 32'hA000_0000) begin nerr++; $display("FAIL b2b_first got %h want a0000000", {sl, sr}); end
    bus_read(5'd2, d); nvec++;
    if (d[25:16] !== 10'd5) begin nerr++; $display("FAIL b2b_level got %0d want 5", d[25:16]); end
    for (int k = 1; k < 6; k++) begin
      pulse_req; nvec++;
      if ({sl, sr} !== 32'hA000_0000 + 32'(k)) begin
        nerr++; $display("FAIL b2b_order[%0d] got %h want %h", k, {sl, sr}, 32'hA000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    bus_write(5'd3, 32'h4);
    bus_write(5'd1, 32'h9);
    bus_read(5'd3, d); nvec++;
    if (d !== 32'h4) begin nerr++; $display("FAIL thresh_read got %h want 4", d); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); cs = 1; wr = 1; addr = 5'd0; wdata = 32'hB000_0000 + 32'(k);
    end
    @(negedge clk); cs = 0; wr = 0;
    @(negedge clk); nvec++;
    if (irq !== 1'b0) begin nerr++; $display("FAIL irq_level6 got %b want 0", irq); end
    pulse_req;
    pulse_req; nvec++;
    if (irq !== 1'b0) begin nerr++; $display("FAIL irq_at_hit got %b want 0", irq); end
    @(negedge clk); nvec++;
    if (irq !== 1'b1) begin nerr++; $display("FAIL irq_rise got %b want 1", irq); end
    bus_write(5'd0, 32'hB000_0006); nvec++;
    if (irq !== 1'b1) begin nerr++; $display("FAIL irq_hold got %b want 1", irq); end
    @(negedge clk); nvec++;
    if (irq !== 1'b0) begin nerr++; $display("FAIL irq_fall got %b want 0", irq); end
  endtask

  task automatic test_clear_reset;
    logic [31:0] d;
    @(negedge clk); cs = 1; wr = 1; addr = 5'd1; wdata = 32'h3; req = 1;
    @(negedge clk); cs = 0; wr = 0; req = 0;
    nvec++;
    if ({strobe, sl, sr} !== 33'h1_0000_0000) begin
      nerr++; $display("FAIL clear_out got %h want 100000000", {strobe, sl, sr});
    end
    bus_read(5'd2, d); nvec++;
    if (d !== 32'h9) begin nerr++; $display("FAIL clear_status got %h want 00000009", d); end
    bus_read(5'd4, d); nvec++;
    if (d !== 32'h0) begin nerr++; $display("FAIL clear_underrun got %h want 0", d); end
    pulse_req;
    bus_read(5'd4, d); nvec++;
    if (d !== 32'h1) begin nerr++; $display("FAIL post_clear_underrun got %h want 1", d); end
    bus_write(5'd0, 32'hC000_0001);
    bus_write(5'd0, 32'hC000_0002);
    pulse_req;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    nvec++;
    if ({sl, sr, strobe, irq} !== 34'h0) begin
      nerr++; $display("FAIL rst_outputs got %h want 0", {sl, sr, strobe, irq});
    end
    bus_read(5'd2, d); nvec++;
    if (d !== 32'h9) begin nerr++; $display("FAIL rst_status got %h want 00000009", d); end
    bus_read(5'd1, d); nvec++;
    if (d !== 32'h0) begin nerr++; $display("FAIL rst_ctrl got %h want 0", d); end
    bus_read(5'd3, d); nvec++;
    if (d !== 32'h0) begin nerr++; $display("FAIL rst_thresh got %h want 0", d); end
    bus_read(5'd4, d); nvec++;
    if (d !== 32'h0) begin nerr++; $display("FAIL rst_underrun got %h want 0", d); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full;
    test_underrun;
    test_back_to_back;
    test_irq;
    test_clear_reset;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
